rd8su_seq: RTL and testbench

- Sequential restoring divider: signed dividend s divided by unsigned divisor u, giving a signed quotient and a signed remainder.
- It is the inverse (division) counterpart of the team's signed x unsigned multiplier family and sits beside those multipliers in the arithmetic datapath.
- Valid/ready handshake on both input and output sides; one operation in flight at a time; one quotient bit resolved per cycle.

---
 rtl/rd8su_seq.sv | 110 +++++++++++
 tb/tb_rd8su_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/rd8su_seq.sv
// Sequential restoring divider: signed dividend by unsigned divisor, one quotient
// bit per cycle, valid/ready on both sides with a single operation in flight.
module rd8su_seq #(
    parameter int unsigned DW = 8,
    parameter int unsigned VW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] s,
    input  logic [VW-1:0] u,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quo,
    output logic [VW:0]   rem,
    output logic          dbz
);

    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [VW:0]   pr;
    logic [DW-1:0] mag;
    logic [DW-1:0] qmag;
    logic [VW-1:0] ud;
    logic          neg;
    logic          zdiv;

    logic [VW:0]   pr_shift;
    logic [VW:0]   pr_sub;
    logic          pr_ge;

    // One restoring step: shift in the next dividend bit and trial-subtract the divisor
    always_comb begin
        pr_shift = {pr[VW-1:0], mag[DW-1]};
        pr_sub   = pr_shift - {1'b0, ud};
        pr_ge    = (pr_shift >= {1'b0, ud});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pr        <= '0;
            mag       <= '0;
            qmag      <= '0;
            ud        <= '0;
            neg       <= 1'b0;
            zdiv      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quo       <= '0;
            rem       <= '0;
            dbz       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        neg      <= s[DW-1];
                        mag      <= s[DW-1] ? -s : s;
                        ud       <= u;
                        pr       <= '0;
                        qmag     <= '0;
                        cnt      <= '0;
                        zdiv     <= (u == '0);
                        state    <= (u == '0) ? FIX : RUN;
                    end
                end
                RUN: begin
                    mag  <= {mag[DW-2:0], 1'b0};
                    pr   <= pr_ge ? pr_sub : pr_shift;
                    qmag <= {qmag[DW-2:0], pr_ge};
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(DW - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // Divide-by-zero saturates toward the dividend's sign
                    if (zdiv) begin
                        quo <= neg ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
                        rem <= '0;
                    end else begin
                        quo <= neg ? -qmag : qmag;
                        rem <= neg ? -pr : pr;
                    end
                    dbz       <= zdiv;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rd8su_seq.sv
// Self-checking bench for rd8su_seq: directed cases from the test plan plus
// randomized operations checked against integer division in the bench.
module tb_rd8su_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] s;
    logic [3:0] u;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quo;
    logic [4:0] rem;
    logic       dbz;

    int passed;
    int total;

    rd8su_seq #(.DW(8), .VW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .u         (u),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quo       (quo),
        .rem       (rem),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: C-style truncating division; remainder takes the dividend's sign
    task automatic model(input logic [7:0] sv, input logic [3:0] uv,
                         output logic [7:0] eq, output logic [4:0] er, output logic ez);
        int sd;
        int ui;
        int q;
        int r;
        sd = int'($signed(sv));
        ui = int'(uv);
        if (ui == 0) begin
            q  = (sd >= 0) ? 127 : -128;
            r  = 0;
            ez = 1'b1;
        end else begin
            q  = sd / ui;
            r  = sd % ui;
            ez = 1'b0;
        end
        eq = q[7:0];
        er = r[4:0];
    endtask

    // One full transaction with bp cycles of backpressure once the result appears
    task automatic run_op(input logic [7:0] sv, input logic [3:0] uv, input int bp);
        logic [7:0] eq;
        logic [4:0] er;
        logic       ez;
        int         lat;
        int         w;
        model(sv, uv, eq, er, ez);
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 30) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        s         = sv;
        u         = uv;
        in_valid  = 1'b1;
        out_ready = (bp == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        s        = 8'($urandom);
        u        = 4'($urandom);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check("latency", 32'(lat), (uv == 4'd0) ? 32'd2 : 32'd10);
        check("quo", 32'(quo), 32'(eq));
        check("rem", 32'(rem), 32'(er));
        check("dbz", 32'(dbz), 32'(ez));
        check("in_ready_busy", 32'(in_ready), 32'd0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_quo", 32'(quo), 32'(eq));
            check("bp_rem", 32'(rem), 32'(er));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] eq;
        logic [4:0] er;
        logic       ez;
        logic [7:0] pend_q;
        logic [4:0] pend_r;
        int         cyc;
        int         last_acc;
        int         n_acc;
        int         n_res;
        int         seen;

        passed    = 0;
        total     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        s         = '0;
        u         = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quo", 32'(quo), 32'd0);
        check("rst_rem", 32'(rem), 32'd0);
        check("rst_dbz", 32'(dbz), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(8'd100, 4'd7, 0);
        check("q_100_7", 32'(quo), 32'h0E);
        run_op(8'h9C, 4'd7, 0);
        check("q_m100_7", 32'(quo), 32'hF2);
        check("r_m100_7", 32'(rem), 32'h1E);
        run_op(8'h80, 4'd1, 0);
        check("q_m128_1", 32'(quo), 32'h80);
        run_op(8'd127, 4'd15, 0);
        check("r_127_15", 32'(rem), 32'h07);
        run_op(8'd5, 4'd0, 0);
        check("q_dbz_pos", 32'(quo), 32'h7F);
        run_op(8'hFD, 4'd0, 0);
        check("q_dbz_neg", 32'(quo), 32'h80);
        run_op(8'd50, 4'd3, 5);
        check("q_50_3", 32'(quo), 32'h10);

        // Reset four cycles into a division
        @(negedge clk);
        s        = 8'hB3;
        u        = 4'd9;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);
        run_op(8'hB3, 4'd9, 0);
        check("q_m77_9", 32'(quo), 32'hF8);
        check("r_m77_9", 32'(rem), 32'h1B);

        // Randomized operations with random backpressure
        for (int k = 0; k < 30; k++) begin
            run_op(8'($urandom), 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        end

        // Back-to-back: in_valid held high, operands change on every accept
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        cyc       = 0;
        last_acc  = -1;
        n_acc     = 0;
        n_res     = 0;
        pend_q    = '0;
        pend_r    = '0;
        while (cyc < 80) begin
            if (out_valid) begin
                check("b2b_quo", 32'(quo), 32'(pend_q));
                check("b2b_rem", 32'(rem), 32'(pend_r));
                n_res++;
            end
            if (in_ready) begin
                s = 8'($urandom);
                u = 4'($urandom_range(1, 15));
                model(s, u, eq, er, ez);
                pend_q = eq;
                pend_r = er;
                if (last_acc >= 0) check("b2b_interval", 32'(cyc - last_acc), 32'd11);
                last_acc = cyc;
                n_acc++;
            end else begin
                s = 8'($urandom);
                u = 4'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("b2b_accepts", 32'(n_acc), 32'd8);
        check("b2b_results", 32'(n_res), 32'd7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
